md_unit: RTL and testbench

Execute-stage multiply/divide unit of the P7 pipeline. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency. It handles MTHI/MTLO writes and supplies the MFHI/MFLO read value on `E_HL`, which the E/M pipeline register captures. It also raises the decode-stage stall for multiply/divide instructions while an operation is in flight.

---
 rtl/md_pkg.sv | 43 ++++
 rtl/md_calc.sv | 60 ++++++
 rtl/md_unit.sv | 98 +++++++++
 tb/tb_md_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the P7 execute-stage multiply/divide unit.
//   - md_op_e      : MD operation codes carried on E_op (unlisted codes are NONE)
//   - latency defaults for multiply-class and divide-class operations
//   - md_is_multi  : op starts a multi-cycle operation
//   - md_is_div    : op uses the divide latency
// Configuration macro: MD_MADD_EN (codes 9/10 become MADD/MADDU; otherwise NONE).
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10
  } md_op_e;

  localparam int unsigned MD_MULT_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF  = 10;

  function automatic logic md_is_multi(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU:                 r = 1'b1;
`endif
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit {hi,lo} result for a multi-cycle MD op.
// Ports:
//   i_op        operation code (md_op_e encoding)
//   i_a, i_b    rs / rt operands
//   i_hi, i_lo  current HI/LO accumulator (present only with MD_MADD_EN)
//   o_res       {hi,lo} result; zero for non-arithmetic ops
// Divide by zero yields hi = i_a, lo = 0xFFFFFFFF for both DIV and DIVU.
// Configuration macro: MD_MADD_EN adds MADD/MADDU accumulate.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
`ifdef MD_MADD_EN
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
`endif
  output logic [63:0] o_res
);

  logic [63:0]        w_sprod;
  logic [63:0]        w_uprod;
  logic signed [31:0] w_squo;
  logic signed [31:0] w_srem;
  logic               w_bzero;
  logic               w_ovf;

  // Operands widened to 64 bits so the low 64 bits of the product are exact.
  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'h0, i_a} * {32'h0, i_b};
  assign w_squo  = $signed(i_a) / $signed(i_b);
  assign w_srem  = $signed(i_a) % $signed(i_b);
  assign w_bzero = (i_b == '0);
  // Most-negative / -1 overflows the quotient; pinned to 0x80000000 rem 0.
  assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == '1);

  always_comb begin
    o_res = '0;
    case (i_op)
      MD_MULT:  o_res = w_sprod;
      MD_MULTU: o_res = w_uprod;
      MD_DIV: begin
        if (w_bzero)    o_res = {i_a, 32'hFFFF_FFFF};
        else if (w_ovf) o_res = {32'h0, 32'h8000_0000};
        else            o_res = {w_srem, w_squo};
      end
      MD_DIVU: begin
        if (w_bzero) o_res = {i_a, 32'hFFFF_FFFF};
        else         o_res = {i_a % i_b, i_a / i_b};
      end
`ifdef MD_MADD_EN
      MD_MADD:  o_res = {i_hi, i_lo} + w_sprod;
      MD_MADDU: o_res = {i_hi, i_lo} + w_uprod;
`endif
      default:  o_res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: P7 execute-stage multiply/divide unit owning HI/LO.
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   Req         flush of the E-stage instruction (blocks start and MT* writes)
//   E_op        MD op in E (md_op_e encoding)
//   E_A, E_B    forwarded rs / rt operands
//   D_md        D-stage instruction is an MD op
//   E_HL        HI for MFHI, LO for MFLO, else 0 (combinational)
//   start       multi-cycle op accepted this cycle (combinational)
//   busy        operation in flight (registered)
//   md_stall    D_md & (start | busy)
// The result is computed at start and held in hi_p/lo_p; HI/LO take it on the
// edge where the countdown reaches zero, so they never expose a partial result.
// Configuration macro: MD_MADD_EN (MADD/MADDU accumulate into HI/LO).
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md,
  output logic [31:0] E_HL,
  output logic        start,
  output logic        busy,
  output logic        md_stall
);

  localparam int unsigned LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_p;
  logic [31:0]      r_lo_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [63:0]      w_res;
  logic [CNT_W-1:0] w_lat;

  md_calc u_calc (
    .i_op  (E_op),
    .i_a   (E_A),
    .i_b   (E_B),
`ifdef MD_MADD_EN
    .i_hi  (r_hi),
    .i_lo  (r_lo),
`endif
    .o_res (w_res)
  );

  assign w_lat    = md_is_div(E_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  assign start    = md_is_multi(E_op) & ~r_busy & ~Req;
  assign busy     = r_busy;
  assign md_stall = D_md & (start | r_busy);

  always_comb begin
    E_HL = '0;
    case (E_op)
      MD_MFHI: E_HL = r_hi;
      MD_MFLO: E_HL = r_lo;
      default: E_HL = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_hi_p <= '0;
      r_lo_p <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      {r_hi_p, r_lo_p} <= w_res;
      r_cnt            <= w_lat;
      r_busy           <= 1'b1;
    end else if (r_busy) begin
      // Req is deliberately ignored here: the in-flight op is older than
      // any flushed instruction and must complete.
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_hi   <= r_hi_p;
        r_lo   <= r_lo_p;
        r_busy <= 1'b0;
      end
    end else if (!Req) begin
      if (E_op == MD_MTHI) r_hi <= E_A;
      if (E_op == MD_MTLO) r_lo <= E_A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a cycle-count based
// reference model (HI/LO commit at an absolute completion cycle).
module tb_md_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MTHI = 4'd5,
                         OP_MTLO = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8,
                         OP_MADD = 4'd9, OP_MADDU = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req = 1'b0;
  logic [3:0]  E_op = '0;
  logic [31:0] E_A = '0;
  logic [31:0] E_B = '0;
  logic        D_md = 1'b0;
  logic [31:0] E_HL;
  logic        start;
  logic        busy;
  logic        md_stall;

  always #5 clk = ~clk;

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .E_op(E_op), .E_A(E_A), .E_B(E_B),
    .D_md(D_md), .E_HL(E_HL), .start(start), .busy(busy), .md_stall(md_stall)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  longint      m_cyc = 0;
  longint      m_done = 0;
  bit          m_chk = 0;

  function automatic bit m_busy();
    return m_cyc < m_done;
  endfunction

  function automatic bit is_mc(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10;
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      OP_MADD:  return {hi, lo} + 64'(sa * sb);
      OP_MADDU: return {hi, lo} + ua * ub;
      default:  return 64'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      bit          b0, st;
      logic [63:0] r;
      b0 = m_busy();
      st = is_mc(E_op) && !b0 && !Req;
      r  = ref_res(E_op, E_A, E_B, m_hi, m_lo);
      m_cyc++;
      if (b0 && m_cyc == m_done) begin
        {m_hi, m_lo} = m_pend;
      end else if (st) begin
        m_pend = r;
        m_done = m_cyc + ((E_op == OP_DIV || E_op == OP_DIVU) ? 10 : 5);
      end else if (!b0 && !Req) begin
        if (E_op == OP_MTHI) m_hi = E_A;
        if (E_op == OP_MTLO) m_lo = E_A;
      end
    end
  end

  always @(negedge rst_n) begin
    m_hi = '0;
    m_lo = '0;
    m_done = m_cyc;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && m_chk) begin
      bit          eb, es;
      logic [31:0] eh;
      eb = m_busy();
      es = is_mc(E_op) && !eb && !Req;
      eh = (E_op == OP_MFHI) ? m_hi : (E_op == OP_MFLO) ? m_lo : 32'h0;
      chk("busy", {31'h0, busy}, {31'h0, eb});
      chk("start", {31'h0, start}, {31'h0, es});
      chk("md_stall", {31'h0, md_stall}, {31'h0, D_md & (es | eb)});
      chk("E_HL", E_HL, eh);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic        s_busy, s_stall, s_start;
  logic [31:0] s_hl;

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic req, input logic dmd);
    E_op = op; E_A = a; E_B = b; Req = req; D_md = dmd;
    @(negedge clk);
    s_busy = busy; s_stall = md_stall; s_start = start; s_hl = E_HL;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, output int nb, output int ns, output logic st);
    step(op, a, b, 1'b0, dmd);
    st = s_start;
    nb = int'(s_busy);
    ns = int'(s_stall);
    for (int i = 0; i < 40; i++) begin
      step(OP_NONE, 32'h0, 32'h0, 1'b0, dmd);
      nb += int'(s_busy);
      ns += int'(s_stall);
      if (!s_busy) break;
    end
    chk("idle_bound", {31'h0, s_busy}, 32'h0);
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    step(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
    hi = s_hl;
    step(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
    lo = s_hl;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb, ns;
    logic        st;
    logic [31:0] hi, lo;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    E_op = OP_MFHI;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_hi", E_HL, 32'h0);
    E_op = OP_MFLO;
    #1;
    chk("rst_lo", E_HL, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_chk = 1;

    // MULT -1 * 2 with D_md held: stall start cycle + 5 busy cycles
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h2, 1'b1, nb, ns, st);
    chk("mult_busy_cycles", nb, 5);
    chk("mult_stall_cycles", ns, 6);
    chk("mult_stall_after", {31'h0, s_stall}, 32'h0);
    read_hilo(hi, lo);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    chk("model_mult_lo", m_lo, 32'hFFFFFFFE);

    // DIV -7 / 2
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b0, nb, ns, st);
    chk("div_busy_cycles", nb, 10);
    read_hilo(hi, lo);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("model_div_hi", m_hi, 32'hFFFFFFFF);

    // DIVU 7 / 0
    run_op(OP_DIVU, 32'h7, 32'h0, 1'b0, nb, ns, st);
    read_hilo(hi, lo);
    chk("divu0_hi", hi, 32'h7);
    chk("divu0_lo", lo, 32'hFFFFFFFF);

    // DIV overflow
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, nb, ns, st);
    read_hilo(hi, lo);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    // MULTU flushed by Req
    step(OP_MTHI, 32'hA5A5, 32'h0, 1'b0, 1'b0);
    step(OP_MTLO, 32'h5A5A, 32'h0, 1'b0, 1'b0);
    step(OP_MULTU, 32'h3, 32'h5, 1'b1, 1'b1);
    chk("req_start", {31'h0, s_start}, 32'h0);
    chk("req_stall", {31'h0, s_stall}, 32'h0);
    step(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("req_busy", {31'h0, s_busy}, 32'h0);
    read_hilo(hi, lo);
    chk("req_hi", hi, 32'hA5A5);
    chk("req_lo", lo, 32'h5A5A);

    // Req at busy cycle 3 does not abort
    nb = 0;
    step(OP_MULTU, 32'h3, 32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(OP_NONE, 32'h0, 32'h0, (i == 2), 1'b0);
      nb += int'(s_busy);
      if (!s_busy) break;
    end
    chk("req_mid_busy_cycles", nb, 5);
    read_hilo(hi, lo);
    chk("req_mid_hi", hi, 32'h0);
    chk("req_mid_lo", lo, 32'hF);

    // MTHI
    step(OP_MTHI, 32'h1234, 32'h0, 1'b0, 1'b0);
    step(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("mthi", s_hl, 32'h1234);

    // Reset at busy cycle 4 of DIV
    step(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) step(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
    E_op = OP_MFHI;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_hi", E_HL, 32'h0);
    E_op = OP_MFLO;
    #1;
    chk("rstmid_lo", E_HL, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (14) step(OP_NONE, 32'h0, 32'h0, 1'b0, 1'b0);
    read_hilo(hi, lo);
    chk("rstmid_late_hi", hi, 32'h0);
    chk("rstmid_late_lo", lo, 32'h0);

    // MADDU accumulate
    step(OP_MTHI, 32'h0, 32'h0, 1'b0, 1'b0);
    step(OP_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    run_op(OP_MADDU, 32'h1, 32'h1, 1'b0, nb, ns, st);
    read_hilo(hi, lo);
`ifdef MD_MADD_EN
    chk("maddu_start", {31'h0, st}, 32'h1);
    chk("maddu_busy_cycles", nb, 5);
    chk("maddu_hi", hi, 32'h1);
    chk("maddu_lo", lo, 32'h0);
`else
    chk("maddu_start", {31'h0, st}, 32'h0);
    chk("maddu_busy_cycles", nb, 0);
    chk("maddu_hi", hi, 32'h0);
    chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? OP_MFHI : OP_MFLO;
      step(op, pick_val(), pick_val(), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
